// File: rtl/fir_sched_pkg.sv
// rtl/fir_sched_pkg.sv - shared widths, tap count and result-width function for the FIR scheduler
package fir_sched_pkg;

    // Default sample width.
    localparam int XW_DEF = 4;

    // Number of history taps held per channel.
    localparam int NTAPS = 3;

    // Result width: the tap weights sum to 2 + NTAPS, so the worst-case
    // result is (2 + NTAPS) * (2**xw - 1); that many growth bits are added.
    function automatic int calc_yw(input int xw);
        return xw + $clog2(NTAPS + 2);
    endfunction

    // Default result width.
    localparam int YW_DEF = calc_yw(XW_DEF);

endpackage

// File: rtl/fir4_core.sv
// rtl/fir4_core.sv - combinational FIR arithmetic y = 2x + h1 + h2 + h3
//
// Ports:
//   x  : current sample (XW bits, unsigned)
//   h1 : most recent history sample
//   h2 : second history sample
//   h3 : oldest history sample
//   y  : full-width result (YW bits)
module fir4_core
    import fir_sched_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = calc_yw(XW)
) (
    input  logic [XW-1:0] x,
    input  logic [XW-1:0] h1,
    input  logic [XW-1:0] h2,
    input  logic [XW-1:0] h3,
    output logic [YW-1:0] y
);

    // Every operand is widened before the sum so no carry is lost.
    assign y = (YW'(x) << 1) + YW'(h1) + YW'(h2) + YW'(h3);

endmodule

// File: rtl/fir_rr_scheduler.sv
// rtl/fir_rr_scheduler.sv - round-robin scheduler sharing one FIR datapath across channels
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   in_valid : per-channel sample request
//   in_x     : per-channel samples, channel i at [i*XW +: XW]
//   in_ready : per-channel grant, at most one-hot
//   clr_ch   : per-channel history-clear strobe
//   y        : filter result
//   y_ch     : channel that produced y
//   y_valid  : y / y_ch valid
//   y_ready  : downstream accepts y
module fir_rr_scheduler
    import fir_sched_pkg::*;
#(
    parameter int  NCH = 4,
    parameter int  XW  = XW_DEF,
    parameter int  YW  = calc_yw(XW),
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*XW-1:0] in_x,
    output logic [NCH-1:0]   in_ready,
    input  logic [NCH-1:0]   clr_ch,
    output logic [YW-1:0]    y,
    output logic [CW-1:0]    y_ch,
    output logic             y_valid,
    input  logic             y_ready
);

    // Last granted channel; the search starts one past it.
    logic [CW-1:0] ptr;

    // Private per-channel histories, h1 newest.
    logic [XW-1:0] h1 [NCH];
    logic [XW-1:0] h2 [NCH];
    logic [XW-1:0] h3 [NCH];

    logic [XW-1:0] x_arr [NCH];

    logic          slot_free;
    logic          gnt_any;
    logic [CW-1:0] gnt_idx;
    logic [CW:0]   cand_sum;
    logic [CW-1:0] cand;
    logic          accept;

    logic          clr_sel;
    logic [XW-1:0] x_sel;
    logic [XW-1:0] tap1;
    logic [XW-1:0] tap2;
    logic [XW-1:0] tap3;
    logic [YW-1:0] core_y;

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign x_arr[i] = in_x[i*XW +: XW];
    end

    // The output register can take a new result if it is empty or draining.
    assign slot_free = !y_valid || y_ready;

    // Round-robin search from ptr+1; the extra bit in cand_sum absorbs the
    // wrap so non-power-of-two channel counts work too.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand_sum = {1'b0, ptr} + (CW+1)'(k);
            if (cand_sum >= (CW+1)'(NCH)) begin
                cand_sum = cand_sum - (CW+1)'(NCH);
            end
            cand = cand_sum[CW-1:0];
            if (!gnt_any && in_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && slot_free && gnt_any) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept = |in_ready;

    // A clear coinciding with the accept makes the result see zero history.
    assign clr_sel = clr_ch[gnt_idx];
    assign x_sel   = x_arr[gnt_idx];
    assign tap1    = clr_sel ? '0 : h1[gnt_idx];
    assign tap2    = clr_sel ? '0 : h2[gnt_idx];
    assign tap3    = clr_sel ? '0 : h3[gnt_idx];

    fir4_core #(
        .XW (XW),
        .YW (YW)
    ) u_core (
        .x  (x_sel),
        .h1 (tap1),
        .h2 (tap2),
        .h3 (tap3),
        .y  (core_y)
    );

    // Output register and arbitration pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
            ptr     <= CW'(NCH - 1);
        end else if (accept) begin
            y       <= core_y;
            y_ch    <= gnt_idx;
            y_valid <= 1'b1;
            ptr     <= gnt_idx;
        end else if (slot_free) begin
            y_valid <= 1'b0;
        end
    end

    // History shift on accept; the shifted-in taps are already zeroed when
    // a clear coincides, leaving h1 = x and h2 = h3 = 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                h1[i] <= '0;
                h2[i] <= '0;
                h3[i] <= '0;
            end else if (accept && gnt_idx == CW'(i)) begin
                h1[i] <= x_sel;
                h2[i] <= tap1;
                h3[i] <= tap2;
            end else if (clr_ch[i]) begin
                h1[i] <= '0;
                h2[i] <= '0;
                h3[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fir_rr_scheduler.sv
// tb/tb_fir_rr_scheduler.sv - self-checking bench for fir_rr_scheduler
module tb_fir_rr_scheduler;

    localparam int NCH = 4;
    localparam int XW  = 4;
    localparam int YW  = 7;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_valid;
    logic [NCH*XW-1:0] in_x;
    logic [NCH-1:0]    in_ready;
    logic [NCH-1:0]    clr_ch;
    logic [YW-1:0]     y;
    logic [CW-1:0]     y_ch;
    logic              y_valid;
    logic              y_ready;

    int total = 0;
    int bad   = 0;

    // Reference model state: per-channel history lists (index 0 newest),
    // last winner, and the output slot.
    int m_h [NCH][3];
    int m_ptr;
    int m_y;
    int m_ych;
    bit m_yv;

    fir_rr_scheduler #(
        .NCH (NCH),
        .XW  (XW),
        .YW  (YW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_x     (in_x),
        .in_ready (in_ready),
        .clr_ch   (clr_ch),
        .y        (y),
        .y_ch     (y_ch),
        .y_valid  (y_valid),
        .y_ready  (y_ready)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int t = 0; t < 3; t++) m_h[c][t] = 0;
        end
        m_ptr = NCH - 1;
        m_y   = 0;
        m_ych = 0;
        m_yv  = 1'b0;
    endfunction

    function automatic int get_x(int c);
        return int'(in_x[c*XW +: XW]);
    endfunction

    function automatic void set_x(int c, int v);
        in_x[c*XW +: XW] = XW'(v);
    endfunction

    // Channel the rules say wins this cycle, or -1.
    function automatic int model_grant();
        int c;
        if (rst) return -1;
        if (m_yv && !y_ready) return -1;
        for (int k = 1; k <= NCH; k++) begin
            c = (m_ptr + k) % NCH;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] model_ready();
        logic [NCH-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // One clock: predict, take the edge, update the model, settle at negedge.
    task automatic step(output int g);
        logic [NCH-1:0] v_clr;
        bit             v_rst;
        bit             v_rdy;
        int             xv;
        int             sum;
        v_clr = clr_ch;
        v_rst = rst;
        v_rdy = y_ready;
        g     = model_grant();
        @(posedge clk);
        if (v_rst) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                xv = get_x(g);
                if (v_clr[g]) begin
                    for (int t = 0; t < 3; t++) m_h[g][t] = 0;
                end
                sum = 2 * xv + m_h[g][0] + m_h[g][1] + m_h[g][2];
                m_h[g][2] = m_h[g][1];
                m_h[g][1] = m_h[g][0];
                m_h[g][0] = xv;
                m_y   = sum;
                m_ych = g;
                m_yv  = 1'b1;
                m_ptr = g;
            end else if (!m_yv || v_rdy) begin
                m_yv = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (c != g && v_clr[c]) begin
                    for (int t = 0; t < 3; t++) m_h[c][t] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        int g;
        rst      = 1'b1;
        in_valid = '0;
        clr_ch   = '0;
        in_x     = '0;
        y_ready  = 1'b1;
        step(g);
        step(g);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int g;
        rst      = 1'b1;
        in_valid = '1;
        in_x     = NCH*XW'($urandom);
        clr_ch   = '0;
        y_ready  = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        step(g);
        total++;
        if (y_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_y_valid: got %b expected 0", y_valid);
        end
        total++;
        if (y !== 7'd0) begin
            bad++;
            $display("FAIL reset_y: got %0d expected 0", y);
        end
        total++;
        if (y_ch !== 2'd0) begin
            bad++;
            $display("FAIL reset_y_ch: got %0d expected 0", y_ch);
        end
        do_reset();
    endtask

    task automatic test_single_channel();
        int g;
        int exp_y [4];
        exp_y = '{30, 45, 60, 75};
        do_reset();
        in_valid = 4'b0001;
        set_x(0, 15);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (in_ready !== 4'b0001) begin
                bad++;
                $display("FAIL single_ready[%0d]: got %b expected 0001", i, in_ready);
            end
            step(g);
            total++;
            if (y !== YW'(exp_y[i]) || y_ch !== 2'd0 || y_valid !== 1'b1) begin
                bad++;
                $display("FAIL single_y[%0d]: got y=%0d ch=%0d v=%b expected y=%0d ch=0 v=1",
                         i, y, y_ch, y_valid, exp_y[i]);
            end
        end
        in_valid = '0;
        step(g);
        total++;
        if (y_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain: got y_valid=%b expected 0", y_valid);
        end
    endtask

    task automatic test_alternate();
        int g;
        int exp_g [6];
        int exp_y [6];
        logic [NCH-1:0] want;
        exp_g = '{0, 2, 0, 2, 0, 2};
        exp_y = '{2, 10, 3, 15, 4, 20};
        do_reset();
        in_valid = 4'b0101;
        set_x(0, 1);
        set_x(2, 5);
        for (int i = 0; i < 6; i++) begin
            want = 4'b0001 << exp_g[i];
            #1;
            total++;
            if (in_ready !== want) begin
                bad++;
                $display("FAIL alt_ready[%0d]: got %b expected %b", i, in_ready, want);
            end
            step(g);
            total++;
            if (y !== YW'(exp_y[i]) || y_ch !== CW'(exp_g[i])) begin
                bad++;
                $display("FAIL alt_y[%0d]: got y=%0d ch=%0d expected y=%0d ch=%0d",
                         i, y, y_ch, exp_y[i], exp_g[i]);
            end
        end
        in_valid = '0;
        step(g);
    endtask

    task automatic test_back_pressure();
        int g;
        int exp_y [3];
        int exp_c [3];
        exp_y = '{14, 6, 21};
        exp_c = '{3, 1, 3};
        do_reset();
        in_valid = 4'b1010;
        set_x(1, 2);
        set_x(3, 7);
        step(g);
        total++;
        if (y !== 7'd4 || y_ch !== 2'd1 || y_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_first: got y=%0d ch=%0d v=%b expected y=4 ch=1 v=1", y, y_ch, y_valid);
        end
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_ready[%0d]: got %b expected 0000", i, in_ready);
            end
            step(g);
            total++;
            if (y !== 7'd4 || y_ch !== 2'd1 || y_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got y=%0d ch=%0d v=%b expected y=4 ch=1 v=1",
                         i, y, y_ch, y_valid);
            end
        end
        y_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(g);
            total++;
            if (y !== YW'(exp_y[i]) || y_ch !== CW'(exp_c[i]) || y_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_resume[%0d]: got y=%0d ch=%0d v=%b expected y=%0d ch=%0d v=1",
                         i, y, y_ch, y_valid, exp_y[i], exp_c[i]);
            end
        end
        in_valid = '0;
        step(g);
    endtask

    task automatic test_clear();
        int g;
        int exp_y [3];
        exp_y = '{8, 12, 16};
        do_reset();
        in_valid = 4'b0010;
        set_x(1, 4);
        for (int i = 0; i < 3; i++) begin
            step(g);
            total++;
            if (y !== YW'(exp_y[i]) || y_ch !== 2'd1) begin
                bad++;
                $display("FAIL clr_fill[%0d]: got y=%0d ch=%0d expected y=%0d ch=1", i, y, y_ch, exp_y[i]);
            end
        end
        clr_ch = 4'b0010;
        set_x(1, 3);
        step(g);
        total++;
        if (y !== 7'd6) begin
            bad++;
            $display("FAIL clr_with_accept: got %0d expected 6", y);
        end
        clr_ch = '0;
        step(g);
        total++;
        if (y !== 7'd9) begin
            bad++;
            $display("FAIL clr_after: got %0d expected 9", y);
        end
        in_valid = '0;
        step(g);
    endtask

    task automatic test_reset_midstream();
        int g;
        do_reset();
        in_valid = 4'b0100;
        set_x(2, 6);
        step(g);
        total++;
        if (y_valid !== 1'b1 || y !== 7'd12) begin
            bad++;
            $display("FAIL mid_pre: got y=%0d v=%b expected y=12 v=1", y, y_valid);
        end
        rst      = 1'b1;
        in_valid = 4'b0110;
        set_x(1, 9);
        y_ready  = 1'b0;
        #1;
        total++;
        if (in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL mid_rst_ready: got %b expected 0000", in_ready);
        end
        step(g);
        total++;
        if (y_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_discard: got y_valid=%b expected 0", y_valid);
        end
        rst      = 1'b0;
        y_ready  = 1'b1;
        in_valid = 4'b0101;
        set_x(0, 5);
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL mid_first_grant: got %b expected 0001", in_ready);
        end
        step(g);
        total++;
        if (y !== 7'd10 || y_ch !== 2'd0) begin
            bad++;
            $display("FAIL mid_first_y: got y=%0d ch=%0d expected y=10 ch=0", y, y_ch);
        end
        step(g);
        total++;
        if (y !== 7'd12 || y_ch !== 2'd2) begin
            bad++;
            $display("FAIL mid_hist_cleared: got y=%0d ch=%0d expected y=12 ch=2", y, y_ch);
        end
        in_valid = '0;
        step(g);
    endtask

    task automatic test_random();
        int g;
        bit hold [NCH];
        logic [NCH-1:0] want;
        do_reset();
        for (int c = 0; c < NCH; c++) hold[c] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!hold[c]) begin
                    in_valid[c] = 1'($urandom_range(0, 1));
                    set_x(c, int'($urandom_range(0, 15)));
                end
                clr_ch[c] = ($urandom_range(0, 15) == 0);
            end
            y_ready = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 99) == 0);
            #1;
            want = model_ready();
            total++;
            if (in_ready !== want) begin
                bad++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", n, in_ready, want);
            end
            step(g);
            for (int c = 0; c < NCH; c++) hold[c] = in_valid[c] && (c != g);
            total++;
            if (y_valid !== m_yv || y !== YW'(m_y) || y_ch !== CW'(m_ych)) begin
                bad++;
                $display("FAIL rand_out[%0d]: got y=%0d ch=%0d v=%b expected y=%0d ch=%0d v=%b",
                         n, y, y_ch, y_valid, m_y, m_ych, m_yv);
            end
        end
        rst      = 1'b0;
        in_valid = '0;
        clr_ch   = '0;
        step(g);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = '0;
        in_x     = '0;
        clr_ch   = '0;
        y_ready  = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_channel();
        test_alternate();
        test_back_pressure();
        test_clear();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
